// File: rtl/spi_pkg.sv
// Shared SPI frame geometry, controller state encoding and peripheral register map.
// Frame layout on the wire, MSB first: {rw, addr[6:0], data[7:0]}.
package spi_pkg;

    localparam int FRAME_W = 16;
    localparam int ADDR_W  = 7;
    localparam int DATA_W  = 8;
    localparam int DIV_W   = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } state_e;

    localparam logic [ADDR_W-1:0] REG_EN_OUT_7_0  = 7'h00;
    localparam logic [ADDR_W-1:0] REG_EN_OUT_15_8 = 7'h01;
    localparam logic [ADDR_W-1:0] REG_DIR_7_0     = 7'h02;
    localparam logic [ADDR_W-1:0] REG_DIR_15_8    = 7'h03;
    localparam logic [ADDR_W-1:0] REG_CTRL        = 7'h04;

    function automatic logic [FRAME_W-1:0] pack_frame(
        input logic              rw,
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] data
    );
        return {rw, addr, data};
    endfunction

endpackage

// File: rtl/spi_controller_if.sv
// Request/status and serial pins of the SPI write controller.
// master = controller side, slave = requester/pin side.
interface spi_controller_if;

    logic                        start;
    logic                        rw;
    logic [spi_pkg::ADDR_W-1:0]  addr;
    logic [spi_pkg::DATA_W-1:0]  wdata;
    logic                        busy;
    logic                        done;
    logic                        SCLK;
    logic                        nCS;
    logic                        COPI;

    modport master (
        input  start, rw, addr, wdata,
        output busy, done, SCLK, nCS, COPI
    );

    modport slave (
        output start, rw, addr, wdata,
        input  busy, done, SCLK, nCS, COPI
    );

endinterface

// File: rtl/spi_phase_timer.sv
// Phase timer: tick is high in the last clk of each CLK_DIV-cycle phase; load restarts a phase.
// No latency beyond the counter register; no backpressure.
module spi_phase_timer #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic tick,
    output logic tick_next
);
    import spi_pkg::*;

    localparam logic [DIV_W-1:0] RELOAD = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] cnt;

    // Saturates at zero so an idle timer never wraps back to 255.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= RELOAD;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tick      = (cnt == '0);
    assign tick_next = load ? (RELOAD == '0) : (cnt <= DIV_W'(1));

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 single-frame writer: 16-bit frame, busy for exactly 35*CLK_DIV clk, all pins registered.
// start is only taken in IDLE; requests while busy are dropped, not queued.
module spi_controller #(
    parameter int CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    spi_controller_if.master bus
);
    import spi_pkg::*;

    state_e             state_q, state_d;
    logic [FRAME_W-1:0] shreg_q, shreg_d;
    logic [3:0]         bitcnt_q, bitcnt_d;
    logic               sclk_q, sclk_d;
    logic               ncs_q, ncs_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               load;
    logic               tick;
    logic               tick_next;

    spi_phase_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .tick      (tick),
        .tick_next (tick_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            sclk_q   <= 1'b0;
            ncs_q    <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            sclk_q   <= sclk_d;
            ncs_q    <= ncs_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        sclk_d   = sclk_q;
        ncs_d    = ncs_q;
        busy_d   = busy_q;
        load     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d  = ST_SETUP;
                    shreg_d  = pack_frame(bus.rw, bus.addr, bus.wdata);
                    bitcnt_d = 4'd15;
                    ncs_d    = 1'b0;
                    busy_d   = 1'b1;
                    load     = 1'b1;
                end
            end
            ST_SETUP: begin
                if (tick) begin
                    state_d = ST_SHIFT;
                    load    = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (tick) begin
                    load = 1'b1;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        // Data advances only on the falling SCLK edge; the final shift empties the register so COPI idles low.
                        sclk_d  = 1'b0;
                        shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
                        if (bitcnt_q == 4'd0) begin
                            state_d = ST_HOLD;
                        end else begin
                            bitcnt_d = bitcnt_q - 4'd1;
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    state_d = ST_GAP;
                    ncs_d   = 1'b1;
                    load    = 1'b1;
                end
            end
            ST_GAP: begin
                if (tick) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered pulse: high exactly in the final GAP cycle.
        done_d = (state_d == ST_GAP) && tick_next;
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.SCLK = sclk_q;
    assign bus.nCS  = ncs_q;
    assign bus.COPI = shreg_q[FRAME_W-1];

endmodule

// File: tb/tb_spi_controller.sv
`timescale 1ns/1ps
module tb_spi_controller;
    import spi_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic       start = 1'b0;
    logic       rw    = 1'b0;
    logic       sel   = 1'b0;
    logic [6:0] addr  = '0;
    logic [7:0] wdata = '0;

    spi_controller_if if2 ();
    spi_controller_if if1 ();

    assign if2.start = start & ~sel;
    assign if2.rw    = rw;
    assign if2.addr  = addr;
    assign if2.wdata = wdata;
    assign if1.start = start & sel;
    assign if1.rw    = rw;
    assign if1.addr  = addr;
    assign if1.wdata = wdata;

    spi_controller #(.CLK_DIV(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.master));
    spi_controller #(.CLK_DIV(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.master));

    wire m_sclk = sel ? if1.SCLK : if2.SCLK;
    wire m_ncs  = sel ? if1.nCS  : if2.nCS;
    wire m_copi = sel ? if1.COPI : if2.COPI;
    wire m_busy = sel ? if1.busy : if2.busy;
    wire m_done = sel ? if1.done : if2.done;

    typedef struct {
        logic [15:0] frame;
        int          busy;
        int          gap;
        int          div;
    } exp_t;

    exp_t       q[$];
    int         n_chk = 0;
    int         n_fail = 0;
    int         frames_seen = 0;
    logic [7:0] regs [0:4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: peripheral model plus frame scoreboard, sampled on the falling clk edge.
    initial begin
        int          busy_cnt, done_cnt, rises, gap_run, gap_last, stab_err, idle_tog;
        int          cyc, last_rise, pmin, pmax;
        logic [15:0] bits;
        logic        p_sclk, p_ncs, p_copi, p_busy;
        exp_t        e;
        for (int i = 0; i < 5; i++) regs[i] = 8'h00;
        busy_cnt = 0; done_cnt = 0; rises = 0; gap_run = 0; gap_last = 0;
        stab_err = 0; idle_tog = 0; cyc = 0; last_rise = -1; pmin = 1000; pmax = 0;
        bits = '0; p_sclk = 1'b0; p_ncs = 1'b1; p_copi = 1'b0; p_busy = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                busy_cnt = 0; done_cnt = 0; rises = 0; stab_err = 0; idle_tog = 0;
                last_rise = -1; pmin = 1000; pmax = 0; bits = '0;
            end else begin
                if (m_busy) busy_cnt++;
                if (m_done) done_cnt++;
                if (m_ncs)  gap_run++;
                if (p_ncs && !m_ncs) begin
                    gap_last = gap_run;
                    gap_run  = 0;
                end
                if (m_ncs && (m_sclk != p_sclk)) idle_tog++;
                if (p_sclk && m_sclk && (m_copi != p_copi)) stab_err++;
                if ((m_copi != p_copi) && !(p_sclk && !m_sclk) && !(p_ncs && !m_ncs)) stab_err++;
                if (!p_sclk && m_sclk && !m_ncs) begin
                    rises++;
                    bits = {bits[14:0], m_copi};
                    if (last_rise >= 0) begin
                        if (cyc - last_rise < pmin) pmin = cyc - last_rise;
                        if (cyc - last_rise > pmax) pmax = cyc - last_rise;
                    end
                    last_rise = cyc;
                end
                if (!p_ncs && m_ncs && rises == 16 && bits[15] && bits[14:8] < 7'd5)
                    regs[bits[14:8]] = bits[7:0];
                if (p_busy && !m_busy) begin
                    frames_seen++;
                    check("frame_expected", q.size() != 0, 1);
                    if (q.size() != 0) begin
                        e = q.pop_front();
                        check("frame_bits", bits, e.frame);
                        check("sclk_rises", rises, 16);
                        check("busy_cycles", busy_cnt, e.busy);
                        check("done_pulses", done_cnt, 1);
                        check("sclk_period_min", pmin, 2 * e.div);
                        check("sclk_period_max", pmax, 2 * e.div);
                        check("copi_stability", stab_err, 0);
                        check("sclk_toggle_ncs_high", idle_tog, 0);
                        if (e.gap > 0) check("ncs_gap", gap_last, e.gap);
                    end
                    busy_cnt = 0; done_cnt = 0; rises = 0; stab_err = 0; idle_tog = 0;
                    last_rise = -1; pmin = 1000; pmax = 0; bits = '0;
                end
            end
            p_sclk = m_sclk; p_ncs = m_ncs; p_copi = m_copi; p_busy = m_busy;
        end
    end

    task automatic send(input logic s, input logic r, input logic [6:0] a, input logic [7:0] d, input int gap);
        exp_t e;
        sel = s; rw = r; addr = a; wdata = d; start = 1'b1;
        e.frame = {r, a, d};
        e.div   = s ? 1 : 2;
        e.busy  = 35 * e.div;
        e.gap   = gap;
        q.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        check("accept_busy", m_busy, 1);
        check("accept_ncs", m_ncs, 0);
        check("accept_copi", m_copi, r);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (m_busy && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_completes"}, n < 300, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, r, seen_before;
        logic p;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ncs_div2",  if2.nCS,  1);
        check("rst_sclk_div2", if2.SCLK, 0);
        check("rst_copi_div2", if2.COPI, 0);
        check("rst_busy_div2", if2.busy, 0);
        check("rst_done_div2", if2.done, 0);
        check("rst_ncs_div1",  if1.nCS,  1);
        check("rst_busy_div1", if1.busy, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single write of 0xA5 to EN_OUT_7_0.
        send(1'b0, 1'b1, REG_EN_OUT_7_0, 8'hA5, 0);
        wait_idle("write_a5");
        check("reg_en_out_7_0", regs[0], 8'hA5);

        // Back-to-back: second start in the cycle right after done.
        send(1'b0, 1'b1, REG_CTRL, 8'h80, 0);
        n = 0;
        while (!m_done && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check("b2b_done_seen", m_done, 1);
        @(posedge clk); #1;
        check("b2b_idle_after_done", m_busy, 0);
        send(1'b0, 1'b1, REG_EN_OUT_15_8, 8'hFF, 3);
        wait_idle("b2b");
        check("reg_ctrl", regs[4], 8'h80);
        check("reg_en_out_15_8", regs[1], 8'hFF);

        // start hammered mid-frame with a different payload.
        send(1'b0, 1'b1, REG_DIR_7_0, 8'h3C, 0);
        for (int k = 0; k < 40; k++) begin
            start = (k % 2 == 0);
            addr  = REG_CTRL;
            wdata = 8'h11;
            @(posedge clk); #1;
        end
        start = 1'b0;
        wait_idle("ignore_start");
        check("reg_dir_7_0", regs[2], 8'h3C);
        check("reg_ctrl_untouched", regs[4], 8'h80);

        // Reset after 7 SCLK rises aborts the frame.
        seen_before = frames_seen;
        sel = 1'b0; rw = 1'b1; addr = REG_EN_OUT_15_8; wdata = 8'h77; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        r = 0; n = 0; p = 1'b0;
        while (r < 7 && n < 400) begin
            @(negedge clk);
            if (m_sclk && !p) r++;
            p = m_sclk;
            n++;
        end
        check("abort_rises_reached", r, 7);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("abort_ncs", m_ncs, 1);
        check("abort_sclk", m_sclk, 0);
        check("abort_busy", m_busy, 0);
        check("abort_done", m_done, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_done", m_done, 0);
        check("abort_no_frame", frames_seen, seen_before);
        check("abort_reg_unchanged", regs[1], 8'hFF);

        // Read frame: shifted but no register write.
        send(1'b0, 1'b0, REG_EN_OUT_7_0, 8'h33, 0);
        wait_idle("read");
        check("read_no_write", regs[0], 8'hA5);

        // Fastest divider.
        send(1'b1, 1'b1, REG_DIR_15_8, 8'h5A, 0);
        wait_idle("div1");
        check("reg_dir_15_8", regs[3], 8'h5A);

        check("queue_drained", q.size(), 0);
        check("frames_total", frames_seen, 6);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_controller.md
SPI_CONTROLLER -- requirements
Module: spi_controller

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, meaning system-clock cycles per SCLK half-period (legal range 1..255).
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  transaction request, sampled each clk.
REQ-005 SHALL have port rw  input  1  R/W bit transmitted as frame bit 15 (1 = write).
REQ-006 SHALL have port addr  input  7  register address, frame bits 14:8.
REQ-007 SHALL have port wdata  input  8  register data, frame bits 7:0.
REQ-008 SHALL have port busy  output  1  high while a frame is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse at frame completion.
REQ-010 SHALL have port SCLK  output  1  serial clock, idle low.
REQ-011 SHALL have port nCS  output  1  chip select, active low, idle high.
REQ-012 SHALL have port COPI  output  1  serial data out, MSB first.

Function
REQ-013 SHALL accept start only in IDLE; on acceptance latch frame {rw,addr,wdata} into a 16-bit shift register, drive nCS low, COPI = frame[15], busy high, all at the same clk edge.
REQ-014 SHALL ignore start while busy (no queueing, latched frame unchanged).
REQ-015 SHALL implement states IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
REQ-016 SETUP: CLK_DIV cycles, nCS low, SCLK low, COPI = frame[15].
REQ-017 SHIFT: 16 bits; each bit = CLK_DIV cycles SCLK low then CLK_DIV cycles SCLK high (SPI mode 0; receiver samples on SCLK rise).
REQ-018 COPI SHALL change only on the clk edge where SCLK falls (end of a high phase), presenting the next bit; COPI stable throughout each SCLK high phase.
REQ-019 Bit counter SHALL count 15 down to 0; after bit 0's high phase, SCLK returns low and state goes to HOLD.
REQ-020 HOLD: CLK_DIV cycles, nCS low, SCLK low, COPI low.
REQ-021 GAP: CLK_DIV cycles, nCS high, SCLK low; done SHALL be high during the last GAP cycle only.
REQ-022 busy SHALL deassert on the edge returning to IDLE; total busy duration exactly 35*CLK_DIV cycles.
REQ-023 start asserted in the cycle after done (IDLE) SHALL be accepted; minimum nCS-high gap between frames is CLK_DIV cycles.
REQ-024 Exactly 16 SCLK rising edges SHALL occur per frame, all while nCS low; SCLK SHALL never toggle while nCS high.
REQ-025 Divider counter width SHALL be 8 bits; counter reloads to CLK_DIV-1 on every phase/state change, no wrap-around glitch.
REQ-026 All outputs SHALL be registered (no combinational path from inputs to SCLK/nCS/COPI).

Reset
REQ-027 On rst_n low, SHALL immediately force: state IDLE, nCS 1, SCLK 0, COPI 0, busy 0, done 0, shift register 0, counters 0.
REQ-028 Reset mid-frame SHALL abort the frame with no done pulse; first frame after reset release starts cleanly from IDLE.

Structure
REQ-029 Package spi_pkg SHALL hold FRAME_W=16, ADDR_W=7, DATA_W=8, state enum, and register address constants 0x00-0x04 shared with the peripheral.
REQ-030 One sub-module spi_phase_timer (CLK_DIV down-counter producing a phase-end tick) SHALL be used; remaining FSM/shift logic in spi_controller.

Verification (bench pairs controller with spi_peripheral, CLK_DIV=2 unless stated)
REQ-031 start, rw=1, addr=0x00, wdata=0xA5 -> COPI bits at SCLK rises = 0x80A5, busy high 70 cycles, done once, peripheral EN_OUT_7_0=0xA5.
REQ-032 Back-to-back: writes 0x04<-0x80 then 0x01<-0xFF, second start in cycle after done -> both registers updated, nCS high >=2 cycles between frames.
REQ-033 start pulsed repeatedly during frame with addr=0x02 -> ignored; only one frame, 16 SCLK rises.
REQ-034 rst_n low after 7 SCLK rises -> nCS=1, SCLK=0 same cycle, no done, peripheral registers unchanged.
REQ-035 CLK_DIV=1, write 0x03<-0x5A -> busy 35 cycles, SCLK period 2 cycles, data received correctly.
REQ-036 rw=0, addr=0x00, wdata=0x33 -> frame 0x0033 shifted, peripheral registers unchanged.
